mersenne_candidate_dispatcher: RTL and testbench

Initiator that drives the Mersenne trial-division factoring unit. Given exponent p and a k range, it generates candidates d = 2kp+1 and issues each one over the factoring unit's start/finished handshake. It collects each divides-result and stops at the first factor, at the end of the range, or on overflow. It sits between the host command interface and one factoring unit.

---
 rtl/mersenne_candidate_dispatcher_if.sv | 33 +++
 rtl/mersenne_candidate_dispatcher.sv | 216 +++++++++++++++++++++
 tb/tb_mersenne_candidate_dispatcher.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mersenne_candidate_dispatcher_if.sv
// Host command/status and factoring-unit handshake bundle for the Mersenne candidate dispatcher.
// The master modport is the dispatcher side; the slave modport is the host plus factoring unit side.
interface mersenne_candidate_dispatcher_if #(
    parameter int BITWIDTH = 32
);
    logic                cmd_start;
    logic                cmd_abort;
    logic [BITWIDTH-1:0] p;
    logic [BITWIDTH-1:0] k_start;
    logic [BITWIDTH-1:0] k_count;
    logic                fac_start;
    logic [BITWIDTH-1:0] fac_p;
    logic [BITWIDTH-1:0] fac_d;
    logic                fac_finished;
    logic                fac_divides;
    logic                busy;
    logic                done;
    logic                found;
    logic                overflow;
    logic [BITWIDTH-1:0] factor;
    logic [BITWIDTH-1:0] k_found;
    logic [BITWIDTH-1:0] tested_count;

    modport master (
        input  cmd_start, cmd_abort, p, k_start, k_count, fac_finished, fac_divides,
        output fac_start, fac_p, fac_d, busy, done, found, overflow, factor, k_found, tested_count
    );

    modport slave (
        output cmd_start, cmd_abort, p, k_start, k_count, fac_finished, fac_divides,
        input  fac_start, fac_p, fac_d, busy, done, found, overflow, factor, k_found, tested_count
    );
endinterface

// File: rtl/mersenne_candidate_dispatcher.sv
// Generates Mersenne factor candidates d = 2kp+1 and issues them to one trial-division unit.
// Optional macro MERSENNE_MOD8_FILTER_EN skips candidates whose d mod 8 is not 1 or 7.
module mersenne_candidate_dispatcher #(
    parameter int BITWIDTH = 32
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    mersenne_candidate_dispatcher_if.master bus
);
    localparam int DW = 2 * BITWIDTH;
    localparam int CW = $clog2(BITWIDTH + 1);

    typedef enum logic [2:0] {
        IDLE, MUL, CHECK, ISSUE, WAIT_ACK, WAIT_RES, NEXT
    } state_t;

    state_t r_state, w_stateNext;

    logic [BITWIDTH-1:0] r_p, r_k, r_remain, r_mplier, r_factor, r_kFound, r_tested, r_facD;
    logic [BITWIDTH-1:0] w_pNext, w_kNext, w_remainNext, w_mplierNext, w_factorNext;
    logic [BITWIDTH-1:0] w_kFoundNext, w_testedNext, w_facDNext, w_remainDec;
    logic [DW-1:0]       r_d, r_step, r_prod, r_mcand;
    logic [DW-1:0]       w_dNext, w_stepNext, w_prodNext, w_mcandNext, w_prodSum;
    logic [CW-1:0]       r_mulCnt, w_mulCntNext;
    logic r_facStart, r_busy, r_done, r_found, r_overflow;
    logic w_facStartNext, w_busyNext, w_doneNext, w_foundNext, w_overflowNext;
    logic w_overLimit, w_passFilter;

    // Candidates must stay below 2^(BITWIDTH/2) so the unit's squaring cannot wrap.
    assign w_overLimit = |r_d[DW-1:BITWIDTH/2];
    assign w_prodSum   = r_prod + (r_mplier[0] ? r_mcand : {DW{1'b0}});
    assign w_remainDec = r_remain - 1'b1;

`ifdef MERSENNE_MOD8_FILTER_EN
    assign w_passFilter = (r_d[2:0] == 3'd1) || (r_d[2:0] == 3'd7);
`else
    assign w_passFilter = 1'b1;
`endif

    always_comb begin
        w_stateNext    = r_state;
        w_pNext        = r_p;
        w_kNext        = r_k;
        w_remainNext   = r_remain;
        w_mplierNext   = r_mplier;
        w_factorNext   = r_factor;
        w_kFoundNext   = r_kFound;
        w_testedNext   = r_tested;
        w_facDNext     = r_facD;
        w_dNext        = r_d;
        w_stepNext     = r_step;
        w_prodNext     = r_prod;
        w_mcandNext    = r_mcand;
        w_mulCntNext   = r_mulCnt;
        w_facStartNext = 1'b0;
        w_busyNext     = r_busy;
        w_doneNext     = 1'b0;
        w_foundNext    = r_found;
        w_overflowNext = r_overflow;

        if (r_state != IDLE && bus.cmd_abort) begin
            w_stateNext = IDLE;
            w_busyNext  = 1'b0;
            w_doneNext  = 1'b1;
            w_foundNext = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_start) begin
                        w_pNext        = bus.p;
                        w_kNext        = bus.k_start;
                        w_remainNext   = bus.k_count;
                        w_mplierNext   = bus.k_start;
                        w_mcandNext    = DW'(bus.p) << 1;
                        w_stepNext     = DW'(bus.p) << 1;
                        w_prodNext     = '0;
                        w_mulCntNext   = '0;
                        w_foundNext    = 1'b0;
                        w_overflowNext = 1'b0;
                        w_factorNext   = '0;
                        w_kFoundNext   = '0;
                        w_testedNext   = '0;
                        if (bus.k_count == '0) begin
                            w_doneNext = 1'b1;
                            w_busyNext = 1'b0;
                        end else begin
                            w_busyNext  = 1'b1;
                            w_stateNext = MUL;
                        end
                    end
                end
                MUL: begin
                    w_prodNext   = w_prodSum;
                    w_mcandNext  = r_mcand << 1;
                    w_mplierNext = r_mplier >> 1;
                    w_mulCntNext = r_mulCnt + 1'b1;
                    if (r_mulCnt == CW'(BITWIDTH - 1)) begin
                        w_dNext     = w_prodSum + 1'b1;
                        w_stateNext = CHECK;
                    end
                end
                CHECK: begin
                    if (w_overLimit) begin
                        w_overflowNext = 1'b1;
                        w_doneNext     = 1'b1;
                        w_busyNext     = 1'b0;
                        w_stateNext    = IDLE;
                    end else if (w_passFilter) begin
                        w_stateNext = ISSUE;
                    end else begin
                        w_stateNext = NEXT;
                    end
                end
                ISSUE: begin
                    // A previously aborted operation may still be running; hold off until the unit is idle.
                    if (bus.fac_finished) begin
                        w_facStartNext = 1'b1;
                        w_facDNext     = r_d[BITWIDTH-1:0];
                        w_testedNext   = r_tested + 1'b1;
                        w_stateNext    = WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (!bus.fac_finished) begin
                        w_stateNext = WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (bus.fac_finished) begin
                        if (bus.fac_divides) begin
                            w_foundNext  = 1'b1;
                            w_factorNext = r_d[BITWIDTH-1:0];
                            w_kFoundNext = r_k;
                            w_doneNext   = 1'b1;
                            w_busyNext   = 1'b0;
                            w_stateNext  = IDLE;
                        end else begin
                            w_stateNext = NEXT;
                        end
                    end
                end
                NEXT: begin
                    w_remainNext = w_remainDec;
                    if (w_remainDec == '0) begin
                        w_doneNext  = 1'b1;
                        w_busyNext  = 1'b0;
                        w_stateNext = IDLE;
                    end else begin
                        w_kNext     = r_k + 1'b1;
                        w_dNext     = r_d + r_step;
                        w_stateNext = CHECK;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_busyNext  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= IDLE;
            r_p        <= '0;
            r_k        <= '0;
            r_remain   <= '0;
            r_mplier   <= '0;
            r_factor   <= '0;
            r_kFound   <= '0;
            r_tested   <= '0;
            r_facD     <= '0;
            r_d        <= '0;
            r_step     <= '0;
            r_prod     <= '0;
            r_mcand    <= '0;
            r_mulCnt   <= '0;
            r_facStart <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_found    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_p        <= w_pNext;
            r_k        <= w_kNext;
            r_remain   <= w_remainNext;
            r_mplier   <= w_mplierNext;
            r_factor   <= w_factorNext;
            r_kFound   <= w_kFoundNext;
            r_tested   <= w_testedNext;
            r_facD     <= w_facDNext;
            r_d        <= w_dNext;
            r_step     <= w_stepNext;
            r_prod     <= w_prodNext;
            r_mcand    <= w_mcandNext;
            r_mulCnt   <= w_mulCntNext;
            r_facStart <= w_facStartNext;
            r_busy     <= w_busyNext;
            r_done     <= w_doneNext;
            r_found    <= w_foundNext;
            r_overflow <= w_overflowNext;
        end
    end

    assign bus.fac_start    = r_facStart;
    assign bus.fac_p        = r_p;
    assign bus.fac_d        = r_facD;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.found        = r_found;
    assign bus.overflow     = r_overflow;
    assign bus.factor       = r_factor;
    assign bus.k_found      = r_kFound;
    assign bus.tested_count = r_tested;
endmodule

// File: tb/tb_mersenne_candidate_dispatcher.sv
// Directed bench for mersenne_candidate_dispatcher with a behavioural trial-division unit.
// Expected tested counts follow MERSENNE_MOD8_FILTER_EN when it is defined for the build.
module tb_mersenne_candidate_dispatcher;
    localparam int BW = 32;

`ifdef MERSENNE_MOD8_FILTER_EN
    localparam int EXP_T29 = 2;
    localparam int EXP_T13 = 4;
`else
    localparam int EXP_T29 = 4;
    localparam int EXP_T13 = 10;
`endif

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    mersenne_candidate_dispatcher_if #(.BITWIDTH(BW)) bus ();

    mersenne_candidate_dispatcher #(.BITWIDTH(BW)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int facLatency = 6;
    int facCnt;
    logic facBusy;
    int startPulses = 0;
    logic prevFacStart = 1'b0;

    // Reference answer for the unit: does d divide 2^p - 1?
    function automatic logic dividesMersenne(input int unsigned pp, input int unsigned dd);
        longint unsigned r = 1;
        if (dd <= 1) return 1'b0;
        for (int i = 0; i < int'(pp); i++) r = (r * 2) % longint'(dd);
        return (r == 1);
    endfunction

    // Behavioural factoring unit: drops finished one cycle after start, raises it after facLatency.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.fac_finished <= 1'b1;
            bus.fac_divides  <= 1'b0;
            facBusy          <= 1'b0;
            facCnt           <= 0;
        end else if (!facBusy && bus.fac_start) begin
            facBusy          <= 1'b1;
            bus.fac_finished <= 1'b0;
            facCnt           <= facLatency;
            bus.fac_divides  <= dividesMersenne(bus.fac_p, bus.fac_d);
        end else if (facBusy) begin
            if (facCnt == 0) begin
                bus.fac_finished <= 1'b1;
                facBusy          <= 1'b0;
            end else begin
                facCnt <= facCnt - 1;
            end
        end
    end

    // Start pulses must be single-cycle and only while the unit reports idle.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (bus.fac_start) begin
                startPulses++;
                checks++;
                if (prevFacStart || !bus.fac_finished) begin
                    errors++;
                    $display("[TB] FAIL fac_start_pulse: width2=%0b finished=%0b required width1 finished1",
                             prevFacStart, bus.fac_finished);
                end
            end
            prevFacStart = bus.fac_start;
        end else begin
            prevFacStart = 1'b0;
        end
    end

    task automatic applyStimulus(input int unsigned pp, input int unsigned ks, input int unsigned kc);
        bus.p         = pp;
        bus.k_start   = ks;
        bus.k_count   = kc;
        bus.cmd_start = 1'b1;
        @(negedge sys_clk);
        bus.cmd_start = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles, input string name);
        bit seen = 0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            @(negedge sys_clk);
            if (bus.done) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s_done_timeout: got no done pulse within %0d cycles, required one", name, maxCycles);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.found, bus.overflow, bus.fac_start} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b required 00000",
                     {bus.busy, bus.done, bus.found, bus.overflow, bus.fac_start});
        end
        checks++;
        if ({bus.factor, bus.k_found, bus.tested_count, bus.fac_d, bus.fac_p} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: factor=%0d k_found=%0d tested=%0d fac_d=%0d fac_p=%0d required all 0",
                     bus.factor, bus.k_found, bus.tested_count, bus.fac_d, bus.fac_p);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_p11();
        applyStimulus(11, 1, 5);
        waitDone(2000, "p11");
        checks++;
        if ({bus.found, bus.overflow, bus.busy} !== 3'b100 || bus.factor !== 32'd23 ||
            bus.k_found !== 32'd1 || bus.tested_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL p11_result: found=%0b ovf=%0b busy=%0b factor=%0d k=%0d tested=%0d required 1 0 0 23 1 1",
                     bus.found, bus.overflow, bus.busy, bus.factor, bus.k_found, bus.tested_count);
        end
        @(negedge sys_clk);
        checks++;
        if (bus.done !== 1'b0 || bus.factor !== 32'd23) begin
            errors++;
            $display("[TB] FAIL p11_hold: done=%0b factor=%0d required done 0 factor 23", bus.done, bus.factor);
        end
    endtask

    task automatic test_p29();
        applyStimulus(29, 1, 10);
        waitDone(3000, "p29");
        checks++;
        if (bus.found !== 1'b1 || bus.factor !== 32'd233 || bus.k_found !== 32'd4) begin
            errors++;
            $display("[TB] FAIL p29_result: found=%0b factor=%0d k=%0d required 1 233 4",
                     bus.found, bus.factor, bus.k_found);
        end
        checks++;
        if (bus.tested_count !== 32'(EXP_T29)) begin
            errors++;
            $display("[TB] FAIL p29_tested: got %0d required %0d", bus.tested_count, EXP_T29);
        end
    endtask

    task automatic test_p13();
        applyStimulus(13, 1, 10);
        waitDone(5000, "p13");
        checks++;
        if (bus.found !== 1'b0 || bus.factor !== 32'd0 || bus.k_found !== 32'd0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL p13_result: found=%0b factor=%0d k=%0d ovf=%0b required 0 0 0 0",
                     bus.found, bus.factor, bus.k_found, bus.overflow);
        end
        checks++;
        if (bus.tested_count !== 32'(EXP_T13)) begin
            errors++;
            $display("[TB] FAIL p13_tested: got %0d required %0d", bus.tested_count, EXP_T13);
        end
    endtask

    task automatic test_overflow();
        int pulsesBefore = startPulses;
        applyStimulus(31, 1100, 5);
        waitDone(500, "overflow");
        checks++;
        if (bus.overflow !== 1'b1 || bus.found !== 1'b0 || bus.tested_count !== 32'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_result: ovf=%0b found=%0b tested=%0d busy=%0b required 1 0 0 0",
                     bus.overflow, bus.found, bus.tested_count, bus.busy);
        end
        checks++;
        if (startPulses !== pulsesBefore) begin
            errors++;
            $display("[TB] FAIL overflow_no_issue: got %0d start pulses required 0", startPulses - pulsesBefore);
        end
    endtask

    task automatic test_zero_count();
        applyStimulus(7, 3, 0);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.overflow !== 1'b0 || bus.tested_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL zero_count: done=%0b busy=%0b ovf=%0b tested=%0d required 1 0 0 0",
                     bus.done, bus.busy, bus.overflow, bus.tested_count);
        end
        @(negedge sys_clk);
    endtask

    task automatic test_abort();
        bit accepted = 0;
        facLatency = 80;
        applyStimulus(13, 1, 10);
        for (int i = 0; i < 500 && !accepted; i++) begin
            @(negedge sys_clk);
            if (!bus.fac_finished) accepted = 1;
        end
        checks++;
        if (!accepted) begin
            errors++;
            $display("[TB] FAIL abort_accept_timeout: unit never went busy, required busy within 500 cycles");
        end
        repeat (2) @(negedge sys_clk);
        bus.cmd_abort = 1'b1;
        @(negedge sys_clk);
        bus.cmd_abort = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.found !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_result: done=%0b busy=%0b found=%0b required 1 0 0",
                     bus.done, bus.busy, bus.found);
        end
        @(negedge sys_clk);
        applyStimulus(11, 1, 5);
        waitDone(3000, "abort_restart");
        checks++;
        if (bus.found !== 1'b1 || bus.factor !== 32'd23 || bus.tested_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL abort_restart: found=%0b factor=%0d tested=%0d required 1 23 1",
                     bus.found, bus.factor, bus.tested_count);
        end
        facLatency = 6;
        repeat (100) @(negedge sys_clk);
    endtask

    task automatic test_back_to_back();
        applyStimulus(11, 1, 5);
        repeat (5) @(negedge sys_clk);
        applyStimulus(13, 1, 10);
        waitDone(2000, "ignored_start");
        checks++;
        if (bus.factor !== 32'd23 || bus.k_found !== 32'd1 || bus.tested_count !== 32'd1 || bus.fac_p !== 32'd11) begin
            errors++;
            $display("[TB] FAIL ignored_start: factor=%0d k=%0d tested=%0d fac_p=%0d required 23 1 1 11",
                     bus.factor, bus.k_found, bus.tested_count, bus.fac_p);
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(13, 1, 10);
        repeat (50) @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.found, bus.fac_start} !== 4'b0 ||
            {bus.fac_d, bus.fac_p, bus.tested_count, bus.factor} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid: busy=%0b fac_start=%0b fac_d=%0d fac_p=%0d tested=%0d required all 0",
                     bus.busy, bus.fac_start, bus.fac_d, bus.fac_p, bus.tested_count);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        applyStimulus(11, 1, 5);
        waitDone(2000, "after_reset");
        checks++;
        if (bus.found !== 1'b1 || bus.factor !== 32'd23) begin
            errors++;
            $display("[TB] FAIL after_reset: found=%0b factor=%0d required 1 23", bus.found, bus.factor);
        end
    endtask

    initial begin
        bus.cmd_start = 1'b0;
        bus.cmd_abort = 1'b0;
        bus.p         = '0;
        bus.k_start   = '0;
        bus.k_count   = '0;
        $display("[TB] starting mersenne_candidate_dispatcher bench");
        test_reset();
        test_p11();
        test_p29();
        test_p13();
        test_overflow();
        test_zero_count();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
